// File: rtl/addr_gen_multi.sv
// addr_gen_multi
//   Multi-channel state-space address generator. It keeps NUM_CNT independent
//   base-address counters, and each counter has its own start, stride and
//   circular length. A request adds an unsigned offset to one selected counter
//   and returns a registered RAM address one cycle later.
//
// Parameters
//   ADDR_WIDTH   RAM address width
//   NUM_CNT      number of counters (>= 1)
//   OFFSET_WIDTH request offset width
//   START_VEC    packed per-counter start address, counter i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   INC_VEC      packed per-counter stride
//   LEN_VEC      packed per-counter circular length, 0 = free-run modulo 2^ADDR_WIDTH
//   SEL_WIDTH    derived counter-select width (not overridable)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active high
//   cnt_inc      bit i: advance counter i by its stride
//   cnt_clr      bit i: reload counter i with its start (wins over cnt_inc)
//   req_valid    address request strobe
//   req_sel      counter selected for the request
//   req_offset   unsigned offset added to the selected counter
//   addr_valid   addr_out valid, one cycle after req_valid
//   addr_out     generated address (holds while no request)
//   wrap_pulse   bit i: counter i wrapped on the last edge
module addr_gen_multi #(
    parameter int unsigned                         ADDR_WIDTH   = 9,
    parameter int unsigned                         NUM_CNT      = 4,
    parameter int unsigned                         OFFSET_WIDTH = 4,
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]       START_VEC    = '0,
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]       INC_VEC      = {NUM_CNT{ADDR_WIDTH'(1)}},
    parameter logic [NUM_CNT*ADDR_WIDTH-1:0]       LEN_VEC      = '0,
    localparam int unsigned                        SEL_WIDTH    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CNT-1:0]      cnt_inc,
    input  logic [NUM_CNT-1:0]      cnt_clr,
    input  logic                    req_valid,
    input  logic [SEL_WIDTH-1:0]    req_sel,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    output logic                    addr_valid,
    output logic [ADDR_WIDTH-1:0]   addr_out,
    output logic [NUM_CNT-1:0]      wrap_pulse
);

    // Elaboration-time parameter sanity: a single subtraction only brings the
    // counter back into its buffer when the stride does not exceed the length.
    if (NUM_CNT < 1) begin : g_bad_num
        $error("addr_gen_multi: NUM_CNT must be at least 1");
    end
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_chk
        localparam logic [ADDR_WIDTH-1:0] LEN_G = LEN_VEC[g*ADDR_WIDTH +: ADDR_WIDTH];
        localparam logic [ADDR_WIDTH-1:0] INC_G = INC_VEC[g*ADDR_WIDTH +: ADDR_WIDTH];
        if ((LEN_G != '0) && (INC_G > LEN_G)) begin : g_bad_stride
            $error("addr_gen_multi: counter %0d stride exceeds its circular length", g);
        end
    end

    logic [ADDR_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [ADDR_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]    wrap_q, wrap_d;
    logic                  addr_valid_q, addr_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Counter next-state logic
    always_comb begin
        logic [ADDR_WIDTH-1:0] start_v;
        logic [ADDR_WIDTH-1:0] inc_v;
        logic [ADDR_WIDTH-1:0] len_v;
        logic [ADDR_WIDTH:0]   rel;
        start_v = '0;
        inc_v   = '0;
        len_v   = '0;
        rel     = '0;
        wrap_d  = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            start_v  = START_VEC[i*ADDR_WIDTH +: ADDR_WIDTH];
            inc_v    = INC_VEC[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_v    = LEN_VEC[i*ADDR_WIDTH +: ADDR_WIDTH];
            cnt_d[i] = cnt_q[i];
            // Position inside the buffer after the step. One extra bit is kept
            // because (LEN-1)+INC can exceed 2^ADDR_WIDTH-1.
            rel = {1'b0, ADDR_WIDTH'(cnt_q[i] - start_v)} + {1'b0, inc_v};
            if (cnt_clr[i]) begin
                cnt_d[i] = start_v;
            end else if (cnt_inc[i]) begin
                if ((len_v != '0) && (rel >= {1'b0, len_v})) begin
                    cnt_d[i]  = cnt_q[i] + inc_v - len_v;
                    wrap_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + inc_v;
                end
            end
        end
    end

    // Request path: uses counter values before this edge's inc/clr
    always_comb begin
        addr_valid_d = req_valid;
        addr_d       = addr_q;
        if (req_valid) begin
            // Selects past the last counter return address 0
            addr_d = '0;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (req_sel == SEL_WIDTH'(i)) begin
                    addr_d = cnt_q[i] + ADDR_WIDTH'(req_offset);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= START_VEC[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            wrap_q       <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            wrap_q       <= wrap_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
        end
    end

    assign addr_valid = addr_valid_q;
    assign addr_out   = addr_q;
    assign wrap_pulse = wrap_q;

endmodule
